// File: rtl/pid_param.sv
// Pitch PID controller with soft-start timer and power sequencing.
// A new sample is taken on vld; PID_cntrl and cntrl_vld follow two clocks later.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   OFF   | powered down: timer and integrator cleared, outputs held at 0
//   SOFT  | soft start: timer ramps each cycle until its upper bits saturate
//   RUN   | timer frozen, normal regulation
module pid_param #(
  parameter int ERR_W    = 10,
  parameter int PID_W    = 12,
  parameter int INT_W    = 18,
  parameter int TMR_W    = 27,
  parameter int SS_W     = 8,
  parameter int D_SHIFT  = 6,
  parameter int FAST_SIM = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwr_up,
  input  logic              rider_off,
  input  logic              vld,
  input  logic [15:0]       ptch,
  input  logic [15:0]       ptch_rt,
  input  logic [4:0]        p_coeff,
  output logic [PID_W-1:0]  PID_cntrl,
  output logic              cntrl_vld,
  output logic [SS_W-1:0]   ss_tmr,
  output logic              sat
);

  localparam int SUM_W   = PID_W + 4;
  localparam int I_SHIFT = (FAST_SIM != 0) ? 1 : 6;
  localparam logic [TMR_W-1:0] TMR_STEP = (FAST_SIM != 0) ? TMR_W'(256) : TMR_W'(1);
  localparam logic signed [SUM_W-1:0] PID_MAX_S = SUM_W'(2 ** (PID_W - 1) - 1);
  localparam logic signed [SUM_W-1:0] PID_MIN_S = ~PID_MAX_S;

  typedef enum logic [1:0] {OFF, SOFT, RUN} state_t;

  state_t state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic             tmr_frozen;
  logic             flush;

  assign tmr_frozen = &timer[TMR_W-1:8];
  assign ss_tmr     = timer[TMR_W-1 -: SS_W];
  // Anything in flight is dropped when entering or sitting in OFF.
  assign flush      = (state == OFF) || !pwr_up;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= OFF;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OFF:     if (pwr_up) state_nxt = SOFT;
      SOFT:    if (tmr_frozen) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = OFF;
    endcase
    if (!pwr_up) state_nxt = OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            timer <= '0;
    else if (!pwr_up || state == OFF)      timer <= '0;
    else if (state == SOFT && !tmr_frozen) timer <= timer + TMR_STEP;
  end

  // Stage 1: error saturation, derivative term and integrator.
  logic                    sat_pos, sat_neg;
  logic signed [ERR_W-1:0] err_sat;
  logic signed [15:0]      rt_shift;
  logic signed [INT_W-1:0] integ, err_ext, int_sum;
  logic                    int_ovf, windup;

  assign sat_pos  = !ptch[15] && (|ptch[14:ERR_W-1]);
  assign sat_neg  =  ptch[15] && !(&ptch[14:ERR_W-1]);
  assign err_sat  = sat_pos ? {1'b0, {(ERR_W-1){1'b1}}} :
                    sat_neg ? {1'b1, {(ERR_W-1){1'b0}}} : ptch[ERR_W-1:0];
  assign rt_shift = $signed(ptch_rt) >>> D_SHIFT;

  assign err_ext  = INT_W'(err_sat);
  assign int_sum  = integ + err_ext;
  assign int_ovf  = (integ[INT_W-1] == err_ext[INT_W-1]) &&
                    (int_sum[INT_W-1] != integ[INT_W-1]);
  // Stop winding up while the output is pinned in the direction the error pushes.
  assign windup   = sat && (err_sat[ERR_W-1] == PID_cntrl[PID_W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            integ <= '0;
    else if (rider_off || state == OFF)    integ <= '0;
    else if (vld && !int_ovf && !windup)   integ <= int_sum;
  end

  logic signed [ERR_W-1:0] err_r;
  logic signed [15:0]      d_r;
  logic                    v1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= '0;
      d_r   <= '0;
      v1    <= 1'b0;
    end else begin
      v1 <= vld && !flush;
      if (vld) begin
        err_r <= err_sat;
        d_r   <= ~rt_shift;
      end
    end
  end

  // Stage 2: P + I + D at extended width, using the post-update integrator.
  logic signed [ERR_W+5:0] p_prod;
  logic signed [INT_W-1:0] i_full;
  logic signed [SUM_W-1:0] p_term, i_term, d_term, sum_nxt, sum_r;
  logic                    v2;

  assign p_prod  = (ERR_W+6)'(err_r) * (ERR_W+6)'($signed({1'b0, p_coeff}));
  assign i_full  = integ >>> I_SHIFT;
  assign p_term  = SUM_W'(p_prod);
  assign i_term  = SUM_W'(i_full);
  assign d_term  = SUM_W'(d_r);
  assign sum_nxt = p_term + i_term + d_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= '0;
      v2    <= 1'b0;
    end else begin
      v2 <= v1 && !flush;
      if (v1) sum_r <= sum_nxt;
    end
  end

  // Output clamp and register.
  logic             over_hi, over_lo;
  logic [PID_W-1:0] pid_nxt;

  assign over_hi = sum_r > PID_MAX_S;
  assign over_lo = sum_r < PID_MIN_S;
  assign pid_nxt = over_hi ? {1'b0, {(PID_W-1){1'b1}}} :
                   over_lo ? {1'b1, {(PID_W-1){1'b0}}} : sum_r[PID_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PID_cntrl <= '0;
      sat       <= 1'b0;
      cntrl_vld <= 1'b0;
    end else if (flush) begin
      PID_cntrl <= '0;
      sat       <= 1'b0;
      cntrl_vld <= 1'b0;
    end else begin
      cntrl_vld <= v2;
      if (v2) begin
        PID_cntrl <= pid_nxt;
        sat       <= over_hi || over_lo;
      end
    end
  end

endmodule

// File: tb/tb_pid_param.sv
// Self-checking bench for pid_param: directed scenarios plus randomized
// traffic compared cycle by cycle against an arithmetic reference model.
module tb_pid_param;

  logic        clk = 1'b0;
  logic        rst_n, pwr_up, rider_off, vld;
  logic [15:0] ptch, ptch_rt;
  logic [4:0]  p_coeff;
  logic [11:0] pid;
  logic        cvld, sat;
  logic [7:0]  ss;
  logic [11:0] pid_s;
  logic        cvld_s, sat_s;
  logic [3:0]  ss_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pid_param dut (
    .clk(clk), .rst_n(rst_n), .pwr_up(pwr_up), .rider_off(rider_off), .vld(vld),
    .ptch(ptch), .ptch_rt(ptch_rt), .p_coeff(p_coeff),
    .PID_cntrl(pid), .cntrl_vld(cvld), .ss_tmr(ss), .sat(sat)
  );

  // Short timer so the freeze point is reachable quickly.
  pid_param #(.TMR_W(12), .SS_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .pwr_up(pwr_up), .rider_off(rider_off), .vld(vld),
    .ptch(ptch), .ptch_rt(ptch_rt), .p_coeff(p_coeff),
    .PID_cntrl(pid_s), .cntrl_vld(cvld_s), .ss_tmr(ss_s), .sat(sat_s)
  );

  // Reference model: each accepted sample becomes a queued result due 2 edges later.
  typedef struct { int due; int val; bit s; } item_t;
  item_t q[$];
  item_t it;
  int    cyc = 0;
  bit    m_on = 0;
  int    m_integ = 0;
  int    m_out = 0;
  bit    m_sat = 0, m_vld = 0;
  bit    m_flush;
  int    pv, err, ni, rv, dd, sum, pc;

  function automatic int wrap16(int x);
    logic signed [15:0] t;
    t = x[15:0];
    return int'(t);
  endfunction

  task automatic model_reset();
    q.delete();
    m_on = 0; m_integ = 0; m_out = 0; m_sat = 0; m_vld = 0;
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      m_flush = !m_on || !pwr_up;
      pv  = $signed(ptch);
      err = (pv > 511) ? 511 : ((pv < -512) ? -512 : pv);
      if (rider_off || !m_on) ni = 0;
      else if (vld) begin
        ni = m_integ + err;
        if (ni > 131071 || ni < -131072) ni = m_integ;
        else if (m_sat && ((err < 0) == (m_out < 0))) ni = m_integ;
      end else ni = m_integ;
      if (m_flush) begin
        q.delete(); m_out = 0; m_sat = 0; m_vld = 0;
      end else begin
        m_vld = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
          it = q.pop_front();
          m_out = it.val; m_sat = it.s; m_vld = 1;
        end
        if (vld) begin
          rv  = $signed(ptch_rt);
          dd  = -(rv >>> 6) - 1;
          pc  = p_coeff;
          sum = wrap16(err * pc + wrap16(ni >>> 1) + dd);
          it.due = cyc + 2;
          it.s   = (sum > 2047) || (sum < -2048);
          it.val = (sum > 2047) ? 2047 : ((sum < -2048) ? -2048 : sum);
          q.push_back(it);
        end
      end
      m_integ = ni;
      m_on    = pwr_up;
      cyc++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    vld = 0; rider_off = 0;
    #1 rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; pwr_up = 0; rider_off = 0; vld = 0;
    ptch = '0; ptch_rt = '0; p_coeff = '0;
    model_reset();
    repeat (3) @(negedge clk);
    n_tests += 6;
    if (pid !== 12'h000) begin n_fail++; $display("FAIL reset_pid: got %h exp 000", pid); end
    if (cvld !== 1'b0)   begin n_fail++; $display("FAIL reset_cvld: got %b exp 0", cvld); end
    if (sat !== 1'b0)    begin n_fail++; $display("FAIL reset_sat: got %b exp 0", sat); end
    if (ss !== 8'h00)    begin n_fail++; $display("FAIL reset_ss: got %h exp 00", ss); end
    if (ss_s !== 4'h0)   begin n_fail++; $display("FAIL reset_ss_small: got %h exp 0", ss_s); end
    if (cvld_s !== 1'b0) begin n_fail++; $display("FAIL reset_cvld_small: got %b exp 0", cvld_s); end
    rst_n = 1;
  endtask

  task automatic test_soft_start();
    int e_main, e_small;
    do_reset();
    pwr_up = 1;
    for (int k = 1; k <= 2050; k++) begin
      @(negedge clk);
      e_main  = ((k - 1) * 256) >> 19;
      e_small = (k - 1 > 15) ? 15 : k - 1;
      n_tests++;
      if (ss !== e_main[7:0]) begin
        n_fail++; $display("FAIL ss_tmr k=%0d: got %h exp %h", k, ss, e_main[7:0]);
      end
      if (k <= 40) begin
        n_tests++;
        if (ss_s !== e_small[3:0]) begin
          n_fail++; $display("FAIL ss_freeze k=%0d: got %h exp %h", k, ss_s, e_small[3:0]);
        end
      end
    end
    pwr_up = 0;
    @(negedge clk);
    n_tests += 2;
    if (ss !== 8'h00)  begin n_fail++; $display("FAIL ss_drop: got %h exp 00", ss); end
    if (ss_s !== 4'h0) begin n_fail++; $display("FAIL ss_drop_small: got %h exp 0", ss_s); end
  endtask

  task automatic test_directed();
    logic [11:0] e_pid;
    // Small positive error with p_coeff=13.
    pwr_up = 1;
    do_reset();
    p_coeff = 5'd13; ptch_rt = 16'h0000;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      n_tests++;
      if (cvld !== (c == 3)) begin n_fail++; $display("FAIL basic_cvld c=%0d: got %b exp %b", c, cvld, c == 3); end
      if (c == 3) begin
        n_tests += 2;
        if (pid !== 12'h0D7) begin n_fail++; $display("FAIL basic_pid: got %h exp 0d7", pid); end
        if (sat !== 1'b0)    begin n_fail++; $display("FAIL basic_sat: got %b exp 0", sat); end
      end
      vld = (c == 0); ptch = 16'h0010;
    end
    // Large negative error saturates; the second sample must not wind up.
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      n_tests++;
      if (cvld !== (c == 3 || c == 6 || c == 7)) begin
        n_fail++; $display("FAIL windup_cvld c=%0d: got %b", c, cvld);
      end
      if (c == 3 || c == 6 || c == 7) begin
        e_pid = (c == 7) ? 12'hEFF : 12'h800;
        n_tests += 2;
        if (pid !== e_pid)   begin n_fail++; $display("FAIL windup_pid c=%0d: got %h exp %h", c, pid, e_pid); end
        if (sat !== (c != 7)) begin n_fail++; $display("FAIL windup_sat c=%0d: got %b exp %b", c, sat, c != 7); end
      end
      vld  = (c == 0 || c == 3 || c == 4);
      ptch = (c == 4) ? 16'h0000 : 16'hF000;
    end
  endtask

  task automatic test_rider_off();
    logic [11:0] exp_v [5];
    exp_v = '{12'hFFF, 12'h00F, 12'h01F, 12'h02F, 12'h03F};
    pwr_up = 1;
    do_reset();
    p_coeff = 5'd0; ptch_rt = 16'h0000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      vld = (c < 3); ptch = 16'h0040;
    end
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      n_tests++;
      if (cvld !== (c >= 3 && c <= 7)) begin n_fail++; $display("FAIL b2b_cvld c=%0d: got %b", c, cvld); end
      if (c >= 3 && c <= 7) begin
        n_tests++;
        if (pid !== exp_v[c-3]) begin n_fail++; $display("FAIL rider_pid c=%0d: got %h exp %h", c, pid, exp_v[c-3]); end
      end
      rider_off = (c == 0); vld = (c <= 4); ptch = 16'h0020;
    end
    rider_off = 0;
  endtask

  task automatic test_overflow();
    pwr_up = 1;
    do_reset();
    p_coeff = 5'd0; ptch_rt = 16'h0000;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      n_tests += 2;
      if (pid !== m_out[11:0] || cvld !== m_vld) begin
        n_fail++; $display("FAIL ovf_model c=%0d: got %h/%b exp %h/%b", c, pid, cvld, m_out[11:0], m_vld);
      end
      if (c > 3 && pid[11] !== 1'b0) begin
        n_fail++; $display("FAIL ovf_sign c=%0d: got %h exp positive", c, pid);
      end
      vld = 1; ptch = 16'h01FF;
    end
    vld = 0;
  endtask

  task automatic test_reset_mid();
    pwr_up = 1;
    do_reset();
    p_coeff = 5'd7; ptch_rt = 16'h0100;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vld = (c == 0 || c == 4); ptch = 16'h0033;
    end
    #1 rst_n = 0;
    model_reset();
    #1;
    n_tests += 3;
    if (pid !== 12'h000) begin n_fail++; $display("FAIL rst_mid_pid: got %h exp 000", pid); end
    if (cvld !== 1'b0)   begin n_fail++; $display("FAIL rst_mid_cvld: got %b exp 0", cvld); end
    if (sat !== 1'b0)    begin n_fail++; $display("FAIL rst_mid_sat: got %b exp 0", sat); end
    vld = 0;
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_tests++;
      if (cvld !== 1'b0 || pid !== 12'h000 || sat !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_after c=%0d: got %b/%h/%b exp 0/000/0", c, cvld, pid, sat);
      end
    end
  endtask

  task automatic test_random();
    int bnd [6];
    bnd = '{511, 512, -512, -513, 32767, -32768};
    pwr_up = 1;
    do_reset();
    p_coeff = 5'd13;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      n_tests += 3;
      if (cvld !== m_vld) begin n_fail++; $display("FAIL rand_cvld c=%0d: got %b exp %b", c, cvld, m_vld); end
      if (pid !== m_out[11:0]) begin n_fail++; $display("FAIL rand_pid c=%0d: got %h exp %h", c, pid, m_out[11:0]); end
      if (sat !== m_sat) begin n_fail++; $display("FAIL rand_sat c=%0d: got %b exp %b", c, sat, m_sat); end
      vld       = ($urandom_range(0, 99) < 60);
      rider_off = ($urandom_range(0, 99) < 4);
      pwr_up    = ($urandom_range(0, 99) >= 3);
      case ($urandom_range(0, 2))
        0:       ptch = 16'(int'($urandom_range(0, 1200)) - 600);
        1:       ptch = 16'($urandom);
        default: ptch = 16'(bnd[$urandom_range(0, 5)]);
      endcase
      ptch_rt = 16'($urandom);
      if (c % 50 == 49) vld = 0;
      if (c % 50 == 0) begin
        vld = 0;
        p_coeff = 5'($urandom_range(0, 31));
      end
    end
    vld = 0; rider_off = 0; pwr_up = 1;
  endtask

  initial begin
    test_reset();
    test_soft_start();
    test_directed();
    test_rider_off();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
